// File: rtl/delay_line_falling.sv
// WIDTH-bit, DEPTH-stage fixed-latency delay line clocked on the falling edge, with
// per-stage valid bits, hold, flush and occupancy count. DELAY_LINE_TAPS_EN exposes all stages.
module delay_line_falling #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_valid,
    output logic [WIDTH-1:0] Dout,
    output logic             Dout_valid,
    output logic [CNT_W-1:0] COUNT,
    output logic             FULL,
`ifdef DELAY_LINE_TAPS_EN
    output logic [DEPTH*WIDTH-1:0] TAPS,
    output logic [DEPTH-1:0]       TAPS_valid,
`endif
    output logic             EMPTY
);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        s_d   = s_q;
        v_d   = v_q;
        cnt_d = cnt_q;
        if (CLR) begin
            s_d   = '{default: '0};
            v_d   = '0;
            cnt_d = '0;
        end else if (EN) begin
            s_d[0] = Din;
            v_d[0] = Din_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
            // Entry and exit in the same edge cancel, so cnt stays within 0..DEPTH.
            cnt_d = cnt_q + CNT_W'(Din_valid) - CNT_W'(v_q[DEPTH-1]);
        end
    end

    // NOTE: the data stages are reset too, because Dout must read 0 while RST_N is low;
    // non-blocking assignments keep every stage sampling the pre-edge value of its neighbour.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_q   <= '{default: '0};
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign Dout       = s_q[DEPTH-1];
    assign Dout_valid = v_q[DEPTH-1];
    assign COUNT      = cnt_q;
    assign FULL       = (cnt_q == CNT_W'(DEPTH));
    assign EMPTY      = (cnt_q == '0);

`ifdef DELAY_LINE_TAPS_EN
    // Stage 0 sits in the least significant word of TAPS.
    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign TAPS[g*WIDTH +: WIDTH] = s_q[g];
    end
    assign TAPS_valid = v_q;
`endif

endmodule

// File: tb/tb_delay_line_falling.sv
// Directed self-checking bench for delay_line_falling: a DEPTH=4 unit and a DEPTH=1 unit
// sharing one stimulus stream; DELAY_LINE_TAPS_EN adds a DEPTH=3 unit and the tap ports.
module tb_delay_line_falling;

    logic       CLK = 1'b1;
    logic       RST_N;
    logic       EN;
    logic       CLR;
    logic [7:0] din;
    logic       din_valid;

    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;

    logic [7:0] d1_dout;
    logic       d1_valid;
    logic [0:0] d1_count;
    logic       d1_full;
    logic       d1_empty;

`ifdef DELAY_LINE_TAPS_EN
    logic [31:0] taps;
    logic [3:0]  taps_valid;
    logic [7:0]  t3_dout;
    logic        t3_valid;
    logic [1:0]  t3_count;
    logic        t3_full;
    logic        t3_empty;
    logic [23:0] t3_taps;
    logic [2:0]  t3_taps_valid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    delay_line_falling #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR),
        .Din(din), .Din_valid(din_valid),
        .Dout(dout), .Dout_valid(dout_valid), .COUNT(count), .FULL(full),
`ifdef DELAY_LINE_TAPS_EN
        .TAPS(taps), .TAPS_valid(taps_valid),
`endif
        .EMPTY(empty)
    );

    delay_line_falling #(.WIDTH(8), .DEPTH(1)) dut_d1 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR),
        .Din(din), .Din_valid(din_valid),
        .Dout(d1_dout), .Dout_valid(d1_valid), .COUNT(d1_count), .FULL(d1_full),
`ifdef DELAY_LINE_TAPS_EN
        .TAPS(), .TAPS_valid(),
`endif
        .EMPTY(d1_empty)
    );

`ifdef DELAY_LINE_TAPS_EN
    delay_line_falling #(.WIDTH(8), .DEPTH(3)) dut_t3 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR),
        .Din(din), .Din_valid(din_valid),
        .Dout(t3_dout), .Dout_valid(t3_valid), .COUNT(t3_count), .FULL(t3_full),
        .TAPS(t3_taps), .TAPS_valid(t3_taps_valid),
        .EMPTY(t3_empty)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic clr, input logic [7:0] d, input logic dv);
        EN        = en;
        CLR       = clr;
        din       = d;
        din_valid = dv;
    endtask

    // Advance one active (falling) edge and settle before sampling.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("rst_dout",  dout,       32'h0);
        check("rst_vld",   dout_valid, 32'h0);
        check("rst_cnt",   count,      32'h0);
        check("rst_full",  full,       32'h0);
        check("rst_empty", empty,      32'h1);
        tick();
        tick();
        RST_N = 1'b1;

        // Latency: one valid word followed by invalid words with X data.
        drive(1'b1, 1'b0, 8'hA5, 1'b1);
        tick();
        check("lat_cnt_e0", count,      32'h1);
        check("lat_vld_e0", dout_valid, 32'h0);
        check("d1_dout_a5", d1_dout,    32'hA5);
        check("d1_vld_a5",  d1_valid,   32'h1);
        drive(1'b1, 1'b0, 8'hxx, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("lat_cnt", count,      32'h1);
            check("lat_vld", dout_valid, (k == 3) ? 32'h1 : 32'h0);
            if (k == 3) check("lat_dout_e3", dout, 32'hA5);
            if (k == 1) begin
                check("d1_vld_bubble", d1_valid, 32'h0);
                check("d1_cnt_bubble", d1_count, 32'h0);
            end
        end
        tick();
        check("lat_cnt_e4",   count,      32'h0);
        check("lat_empty_e4", empty,      32'h1);
        check("lat_vld_e4",   dout_valid, 32'h0);

        // Full / steady streaming of 0x01..0x06.
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 1'b0, 8'(j + 1), 1'b1);
            tick();
            check("stm_cnt",  count, (j < 3) ? 32'(j + 1) : 32'h4);
            check("stm_full", full,  (j >= 3) ? 32'h1 : 32'h0);
            check("stm_vld",  dout_valid, (j >= 3) ? 32'h1 : 32'h0);
            if (j >= 3) check("stm_dout", dout, 32'(j - 2));
            check("d1_dout", d1_dout, 32'(j + 1));
            check("d1_full", d1_full, 32'h1);
`ifdef DELAY_LINE_TAPS_EN
            if (j == 2) begin
                check("t3_taps",     t3_taps,       32'h010203);
                check("t3_taps_vld", t3_taps_valid, 32'h7);
                check("t3_full",     t3_full,       32'h1);
            end
            if (j == 3) begin
                check("taps",     taps,       32'h01020304);
                check("taps_vld", taps_valid, 32'hF);
            end
`endif
        end

        // Flush with EN low, then stall with two words in flight.
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        check("fl_cnt",    count,      32'h0);
        check("fl_empty",  empty,      32'h1);
        check("fl_vld",    dout_valid, 32'h0);
        check("fl_dout",   dout,       32'h0);
        check("fl_d1_cnt", d1_count,   32'h0);
        drive(1'b1, 1'b0, 8'h31, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h32, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("st_pre_dout", dout,       32'h31);
        check("st_pre_vld",  dout_valid, 32'h1);
        check("st_pre_cnt",  count,      32'h2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, k[0] ? 8'h55 : 8'hAA, 1'b1);
            tick();
            check("st_dout",  dout,       32'h31);
            check("st_vld",   dout_valid, 32'h1);
            check("st_cnt",   count,      32'h2);
            check("st_empty", empty,      32'h0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check("rs_dout", dout,       32'h32);
        check("rs_vld",  dout_valid, 32'h1);
        check("rs_cnt",  count,      32'h1);
        tick();
        check("rs_vld_end",   dout_valid, 32'h0);
        check("rs_empty_end", empty,      32'h1);

        // CLR wins over EN; the word offered on that edge must never emerge.
        drive(1'b1, 1'b0, 8'h10, 1'b1);
        tick();
        check("fe_cnt_pre", count, 32'h1);
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        tick();
        check("fe_cnt",    count,      32'h0);
        check("fe_empty",  empty,      32'h1);
        check("fe_vld",    dout_valid, 32'h0);
        check("fe_d1_vld", d1_valid,   32'h0);
        check("fe_d1_out", d1_dout,    32'h0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fe_dout_drain", dout,       32'h0);
            check("fe_vld_drain",  dout_valid, 32'h0);
        end

        // Asynchronous reset in the middle of a full pipe, between edges.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'((k + 1) * 8'h11), 1'b1);
            tick();
        end
        check("ar_full_pre", full, 32'h1);
        check("ar_dout_pre", dout, 32'h11);
        #2;
        RST_N = 1'b0;
        #1;
        check("ar_dout",  dout,       32'h0);
        check("ar_vld",   dout_valid, 32'h0);
        check("ar_cnt",   count,      32'h0);
        check("ar_empty", empty,      32'h1);
        check("ar_full",  full,       32'h0);
        tick();
        check("ar_hold_cnt", count, 32'h0);
        RST_N = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("ar_post_cnt", count,      32'h0);
        check("ar_post_vld", dout_valid, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
